// File: rtl/dl_top.sv
// Digital lock: 3-digit hex password with set/verify/freeze states and 7-segment readout.
// Latency: a button action lands on the 3rd rising i_clk edge that samples the button high.
// Backpressure: none; presses during FREEZE, or losing a same-cycle conflict, are dropped.
//
// Ports:
//   i_clk, i_hard_reset (async active-low; deassertion synchronized internally)
//   i_digit           hex digit to enter
//   i_confirm_getter  push-button, shifts i_digit into the 3-digit entry buffer
//   i_confirm_FSM     push-button, submits the entry buffer to the state machine
//   i_switch          push-button, VERIFY -> SET
//   i_en_display      1 shows the entry buffer, 0 blanks it
//   o_7seg_input      live i_digit glyph (never blanked)
//   o_7seg2/1/0       entry buffer, oldest digit on o_7seg2
//   o_state_7seg      S / U / F glyph
//   o_trials_7seg     remaining trials
//   o_correct_led, o_incorrect_led  result of the last verification
module dl_top #(
  parameter int FREEZE_CYCLES = 500
) (
  input  logic       i_clk,
  input  logic       i_hard_reset,
  input  logic [3:0] i_digit,
  input  logic       i_confirm_getter,
  input  logic       i_confirm_FSM,
  input  logic       i_en_display,
  input  logic       i_switch,
  output logic [6:0] o_7seg_input,
  output logic [6:0] o_7seg2,
  output logic [6:0] o_7seg1,
  output logic [6:0] o_7seg0,
  output logic [6:0] o_state_7seg,
  output logic [6:0] o_trials_7seg,
  output logic       o_correct_led,
  output logic       o_incorrect_led
);

  localparam int CW = (FREEZE_CYCLES > 1) ? $clog2(FREEZE_CYCLES) : 1;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_SET    = 2'd0,
    ST_VERIFY = 2'd1,
    ST_FREEZE = 2'd2
  } state_e;

  // Active-low hex font, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Reset: asserts asynchronously, releases on the 2nd clock edge.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  always_ff @(posedge i_clk or negedge i_hard_reset) begin
    if (!i_hard_reset) rst_sync_q <= 2'b00;
    else               rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  // Button conditioning, bit 0 = getter, 1 = confirm_FSM, 2 = switch.
  // sync1 -> sync2 -> prev; a press is sync2 high while prev is still low.
  logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [2:0] btn_edge;

  always_comb begin
    sync1_d  = {i_switch, i_confirm_FSM, i_confirm_getter};
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    btn_edge = sync2_q & ~prev_q;
  end

  logic get_evt, cfm_evt, sw_evt;
  assign get_evt = btn_edge[0];
  assign cfm_evt = btn_edge[1];
  assign sw_evt  = btn_edge[2];

  // Lock state.
  state_e         state_q, state_d;
  logic [11:0]    pw_q, pw_d;
  logic [11:0]    buf_q, buf_d;      // [11:8] oldest, [3:0] newest
  logic [1:0]     trials_q, trials_d;
  logic           cled_q, cled_d;
  logic           iled_q, iled_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    pw_d     = pw_q;
    buf_d    = buf_q;
    trials_d = trials_q;
    cled_d   = cled_q;
    iled_d   = iled_q;
    cnt_d    = cnt_q;

    case (state_q)
      ST_SET: begin
        if (cfm_evt) begin
          pw_d     = buf_q;
          state_d  = ST_VERIFY;
          trials_d = 2'd3;
          cled_d   = 1'b0;
          iled_d   = 1'b0;
          buf_d    = '0;
        end else if (get_evt) begin
          buf_d = {buf_q[7:0], i_digit};
        end
      end

      ST_VERIFY: begin
        if (cfm_evt) begin
          buf_d = '0;
          if (buf_q == pw_q) begin
            cled_d   = 1'b1;
            iled_d   = 1'b0;
            trials_d = 2'd3;
          end else begin
            cled_d = 1'b0;
            iled_d = 1'b1;
            if (trials_q != 2'd0) trials_d = trials_q - 2'd1;
            // Last trial spent: lock out.
            if (trials_q <= 2'd1) begin
              state_d = ST_FREEZE;
              cnt_d   = '0;
            end
          end
        end else if (sw_evt) begin
          state_d = ST_SET;
          cled_d  = 1'b0;
          iled_d  = 1'b0;
        end else if (get_evt) begin
          buf_d = {buf_q[7:0], i_digit};
        end
      end

      ST_FREEZE: begin
        buf_d  = '0;
        cled_d = 1'b0;
        iled_d = 1'b1;
        // cnt counts 0..FREEZE_CYCLES-1, so the lock spends exactly FREEZE_CYCLES cycles here.
        if (cnt_q == CW'(FREEZE_CYCLES - 1)) begin
          state_d  = ST_VERIFY;
          trials_d = 2'd3;
          cled_d   = 1'b0;
          iled_d   = 1'b0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_SET;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      state_q  <= ST_SET;
      pw_q     <= '0;
      buf_q    <= '0;
      trials_q <= 2'd3;
      cled_q   <= 1'b0;
      iled_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      state_q  <= state_d;
      pw_q     <= pw_d;
      buf_q    <= buf_d;
      trials_q <= trials_d;
      cled_q   <= cled_d;
      iled_q   <= iled_d;
      cnt_q    <= cnt_d;
    end
  end

  // Display.
  always_comb begin
    o_7seg_input = hex7(i_digit);
    o_7seg2      = i_en_display ? hex7(buf_q[11:8]) : SEG_BLANK;
    o_7seg1      = i_en_display ? hex7(buf_q[7:4])  : SEG_BLANK;
    o_7seg0      = i_en_display ? hex7(buf_q[3:0])  : SEG_BLANK;
    case (state_q)
      ST_SET:    o_state_7seg = 7'b0010010;
      ST_VERIFY: o_state_7seg = 7'b1000001;
      ST_FREEZE: o_state_7seg = 7'b0001110;
      default:   o_state_7seg = SEG_BLANK;
    endcase
    o_trials_7seg = hex7({2'b00, trials_q});
  end

  assign o_correct_led   = cled_q;
  assign o_incorrect_led = iled_q;

endmodule

// File: tb/tb_dl_top.sv
module tb_dl_top;

  localparam int FC = 60;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] G_S = 7'b0010010;
  localparam logic [6:0] G_U = 7'b1000001;
  localparam logic [6:0] G_F = 7'b0001110;
  localparam logic [6:0] FONT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] digit;
  logic       b_get, b_cfm, b_sw, en;
  logic [6:0] s_in, s2, s1, s0, s_st, s_tr;
  logic       led_c, led_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dl_top #(.FREEZE_CYCLES(FC)) dut (
    .i_clk(clk), .i_hard_reset(rst_n), .i_digit(digit),
    .i_confirm_getter(b_get), .i_confirm_FSM(b_cfm), .i_en_display(en), .i_switch(b_sw),
    .o_7seg_input(s_in), .o_7seg2(s2), .o_7seg1(s1), .o_7seg0(s0),
    .o_state_7seg(s_st), .o_trials_7seg(s_tr),
    .o_correct_led(led_c), .o_incorrect_led(led_i));

  // ---------------- reference model (action level) ----------------
  int         m_st;          // 0 = SET, 1 = VERIFY, 2 = FREEZE
  logic [3:0] m_q[$];        // entered digits, newest at the back
  logic [3:0] m_pw[3];       // index 2 = first-entered digit
  int         m_tr;
  bit         m_cl, m_il;

  // Buffer position: 2 = oldest of the last three, 0 = newest; missing entries read as 0.
  function automatic logic [3:0] ent(int pos);
    int n;
    n = m_q.size();
    if (pos < n) return m_q[n - 1 - pos];
    return 4'h0;
  endfunction

  task automatic m_reset();
    m_st = 0; m_q.delete(); m_tr = 3; m_cl = 0; m_il = 0;
    for (int i = 0; i < 3; i++) m_pw[i] = 4'h0;
  endtask

  task automatic m_getter(input logic [3:0] d);
    if (m_st != 2) begin
      m_q.push_back(d);
      if (m_q.size() > 3) void'(m_q.pop_front());
    end
  endtask

  task automatic m_confirm();
    bit ok;
    if (m_st == 0) begin
      for (int i = 0; i < 3; i++) m_pw[i] = ent(i);
      m_st = 1; m_tr = 3; m_cl = 0; m_il = 0; m_q.delete();
    end else if (m_st == 1) begin
      ok = 1;
      for (int i = 0; i < 3; i++) if (ent(i) != m_pw[i]) ok = 0;
      if (ok) begin
        m_cl = 1; m_il = 0; m_tr = 3;
      end else begin
        m_cl = 0; m_il = 1;
        if (m_tr > 0) m_tr = m_tr - 1;
        if (m_tr == 0) m_st = 2;
      end
      m_q.delete();
    end
  endtask

  task automatic m_switch();
    if (m_st == 1) begin
      m_st = 0; m_cl = 0; m_il = 0;
    end
  endtask

  task automatic m_freeze_done();
    m_st = 1; m_tr = 3; m_cl = 0; m_il = 0; m_q.delete();
  endtask

  function automatic logic [43:0] exp_vec();
    logic [6:0] g;
    g = (m_st == 0) ? G_S : (m_st == 1) ? G_U : G_F;
    return {FONT[digit],
            en ? FONT[ent(2)] : BLANK, en ? FONT[ent(1)] : BLANK, en ? FONT[ent(0)] : BLANK,
            g, FONT[m_tr], m_cl, m_il};
  endfunction

  function automatic logic [43:0] act_vec();
    return {s_in, s2, s1, s0, s_st, s_tr, led_c, led_i};
  endfunction

  // ---------------- stimulus ----------------
  // which: bit0 getter, bit1 confirm_FSM, bit2 switch
  task automatic press(input int which, input int hold);
    @(negedge clk);
    b_get = which[0]; b_cfm = which[1]; b_sw = which[2];
    repeat (hold) @(negedge clk);
    b_get = 0; b_cfm = 0; b_sw = 0;
    repeat (4) @(negedge clk);
    if (which[1]) m_confirm();
    else if (which[0]) m_getter(digit);
    if (which[2] && !which[1]) m_switch();
  endtask

  task automatic enter3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    digit = a; press(1, $urandom_range(1, 4));
    digit = b; press(1, $urandom_range(1, 4));
    digit = c; press(1, $urandom_range(1, 4));
  endtask

  task automatic hard_reset();
    @(negedge clk);
    #2 rst_n = 0;
    m_reset();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    digit = 4'($urandom_range(0, 15));
    hard_reset();
    #1;
    if (act_vec() !== exp_vec()) begin errors++; $display("FAIL reset_async: got %h want %h", act_vec(), exp_vec()); end
    checks++;
    release_reset();
    if (act_vec() !== exp_vec()) begin errors++; $display("FAIL reset_release: got %h want %h", act_vec(), exp_vec()); end
    checks++;
  endtask

  task automatic test_set_verify();
    enter3(4'hB, 4'hA, 4'hD);
    if (act_vec() !== exp_vec() || s2 !== FONT[11] || s0 !== FONT[13]) begin
      errors++; $display("FAIL set_entry_BAD: got %h want %h", act_vec(), exp_vec()); end
    checks++;
    press(2, 2);
    if (act_vec() !== exp_vec() || s_st !== G_U) begin
      errors++; $display("FAIL set_confirm: got %h want %h", act_vec(), exp_vec()); end
    checks++;
  endtask

  task automatic test_blank_correct();
    en = 0;
    enter3(4'hB, 4'hA, 4'hD);
    if (act_vec() !== exp_vec() || s1 !== BLANK) begin
      errors++; $display("FAIL blank_entry: got %h want %h", act_vec(), exp_vec()); end
    checks++;
    press(2, 3);
    if (act_vec() !== exp_vec() || led_c !== 1'b1) begin
      errors++; $display("FAIL verify_correct: got %h want %h", act_vec(), exp_vec()); end
    checks++;
    en = 1;
  endtask

  task automatic test_wrong_to_freeze();
    for (int k = 0; k < 3; k++) begin
      enter3(4'hF, 4'hA, 4'hD);
      press(2, 1);
      if (act_vec() !== exp_vec() || led_i !== 1'b1) begin
        errors++; $display("FAIL wrong_try%0d: got %h want %h", k, act_vec(), exp_vec()); end
      checks++;
    end
  endtask

  task automatic test_freeze_ignore();
    enter3(4'h1, 4'h2, 4'h3);
    press(2, 1);
    press(4, 1);
    if (act_vec() !== exp_vec() || s_st !== G_F) begin
      errors++; $display("FAIL freeze_ignore: got %h want %h", act_vec(), exp_vec()); end
    checks++;
    repeat (FC + 2) @(negedge clk);
    m_freeze_done();
    if (act_vec() !== exp_vec()) begin errors++; $display("FAIL freeze_exit: got %h want %h", act_vec(), exp_vec()); end
    checks++;
  endtask

  task automatic test_freeze_timing();
    enter3(4'hF, 4'hA, 4'hD); press(2, 1);
    enter3(4'hF, 4'hA, 4'hD); press(2, 1);
    enter3(4'hF, 4'hA, 4'hD);
    @(negedge clk); b_cfm = 1;
    repeat (3) @(negedge clk);
    b_cfm = 0;
    m_confirm();
    if (act_vec() !== exp_vec()) begin errors++; $display("FAIL freeze_entry: got %h want %h", act_vec(), exp_vec()); end
    checks++;
    repeat (FC - 1) @(negedge clk);
    if (act_vec() !== exp_vec()) begin errors++; $display("FAIL freeze_last_cycle: got %h want %h", act_vec(), exp_vec()); end
    checks++;
    @(negedge clk);
    m_freeze_done();
    if (act_vec() !== exp_vec()) begin errors++; $display("FAIL freeze_boundary: got %h want %h", act_vec(), exp_vec()); end
    checks++;
  endtask

  task automatic test_reset_in_freeze();
    for (int k = 0; k < 3; k++) begin enter3(4'h0, 4'h0, 4'h1); press(2, 1); end
    if (act_vec() !== exp_vec() || s_st !== G_F) begin
      errors++; $display("FAIL refreeze: got %h want %h", act_vec(), exp_vec()); end
    checks++;
    hard_reset();
    #1;
    if (act_vec() !== exp_vec() || s_st !== G_S) begin
      errors++; $display("FAIL reset_in_freeze: got %h want %h", act_vec(), exp_vec()); end
    checks++;
    release_reset();
    enter3(4'hF, 4'hA, 4'hD);
    press(2, 2);
    if (act_vec() !== exp_vec() || s_st !== G_U) begin
      errors++; $display("FAIL after_reset_set: got %h want %h", act_vec(), exp_vec()); end
    checks++;
  endtask

  task automatic test_switch();
    press(4, 2);
    if (act_vec() !== exp_vec() || s_st !== G_S) begin
      errors++; $display("FAIL switch_to_set: got %h want %h", act_vec(), exp_vec()); end
    checks++;
    enter3(4'h9, 4'h1, 4'hA); press(2, 1);
    enter3(4'h9, 4'h1, 4'hA); press(2, 1);
    if (act_vec() !== exp_vec() || led_c !== 1'b1) begin
      errors++; $display("FAIL switch_new_pw: got %h want %h", act_vec(), exp_vec()); end
    checks++;
  endtask

  task automatic test_hold();
    digit = 4'h7;
    @(negedge clk); b_get = 1;
    repeat (2) @(negedge clk);
    if (act_vec() !== exp_vec()) begin errors++; $display("FAIL hold_early: got %h want %h", act_vec(), exp_vec()); end
    checks++;
    @(negedge clk);
    m_getter(4'h7);
    if (act_vec() !== exp_vec()) begin errors++; $display("FAIL hold_third_edge: got %h want %h", act_vec(), exp_vec()); end
    checks++;
    repeat (22) @(negedge clk);
    b_get = 0;
    repeat (5) @(negedge clk);
    if (act_vec() !== exp_vec()) begin errors++; $display("FAIL hold_single: got %h want %h", act_vec(), exp_vec()); end
    checks++;
  endtask

  task automatic test_coincide();
    digit = 4'h5;
    press(3, 2);
    if (act_vec() !== exp_vec()) begin errors++; $display("FAIL coincide: got %h want %h", act_vec(), exp_vec()); end
    checks++;
  endtask

  task automatic test_random();
    int op;
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 9);
      digit = 4'($urandom_range(0, 15));
      if (op < 5) press(1, $urandom_range(1, 30));
      else if (op == 5) press(2, $urandom_range(1, 30));
      else if (op == 6) press(4, $urandom_range(1, 30));
      else if (op == 7) begin en = ~en; @(negedge clk); end
      else if (op == 8) begin enter3(m_pw[2], m_pw[1], m_pw[0]); press(2, 2); end
      else @(negedge clk);
      if (act_vec() !== exp_vec()) begin errors++; $display("FAIL random_op%0d_%0d: got %h want %h", n, op, act_vec(), exp_vec()); end
      checks++;
      if (m_st == 2) begin
        repeat (FC + 2) @(negedge clk);
        m_freeze_done();
        if (act_vec() !== exp_vec()) begin errors++; $display("FAIL random_unfreeze%0d: got %h want %h", n, act_vec(), exp_vec()); end
        checks++;
      end
    end
  endtask

  initial begin
    rst_n = 0; digit = 0; b_get = 0; b_cfm = 0; b_sw = 0; en = 1;
    m_reset();
    repeat (3) @(negedge clk);
    test_reset();
    test_set_verify();
    test_blank_correct();
    test_wrong_to_freeze();
    test_freeze_ignore();
    test_freeze_timing();
    test_reset_in_freeze();
    test_switch();
    test_hold();
    test_coincide();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
